// File: rtl/ram_pkg.sv
// Shared encodings for the RAM responder: access-size codes and FSM states.
package ram_pkg;

    localparam logic [2:0] RC_W  = 3'b000;
    localparam logic [2:0] RC_H  = 3'b001;
    localparam logic [2:0] RC_HU = 3'b010;
    localparam logic [2:0] RC_B  = 3'b011;
    localparam logic [2:0] RC_BU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic rc_reserved(input logic [2:0] ctrl);
        return ctrl > RC_BU;
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Combinational little-endian lane steering: store byte mask and merged word, load extraction
// and extension. Offsets are implicitly aligned down; o_misalign flags what was dropped.
module ram_lane_align
    import ram_pkg::*;
(
    input  logic [2:0]  i_ctrl,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_rep;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        o_be    = 4'b0000;
        w_rep   = i_wdata;
        w_half  = i_off[1] ? i_rword[31:16] : i_rword[15:0];
        w_byte  = i_rword[{i_off, 3'b000} +: 8];
        o_rdata = i_rword;
        case (i_ctrl)
            RC_W: begin
                o_be    = 4'b1111;
                o_rdata = i_rword;
            end
            RC_H, RC_HU: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                w_rep   = {2{i_wdata[15:0]}};
                o_rdata = (i_ctrl == RC_H) ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
            end
            RC_B, RC_BU: begin
                o_be    = 4'b0001 << i_off;
                w_rep   = {4{i_wdata[7:0]}};
                o_rdata = (i_ctrl == RC_B) ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
            end
            default: o_be = 4'b0000;
        endcase
    end

    always_comb begin
        o_wword = i_rword;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) o_wword[8*i +: 8] = w_rep[8*i +: 8];
        end
    end

    assign o_misalign = ((i_ctrl == RC_W) && (i_off != 2'b00)) ||
                        (((i_ctrl == RC_H) || (i_ctrl == RC_HU)) && i_off[0]);

endmodule

// File: rtl/ram_responder.sv
// Latency-programmable data-memory responder. Define MISALIGN_TRAP_EN to fault misaligned
// accesses with err; otherwise they are aligned down silently.
module ram_responder
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] Addr,
    input  logic [31:0] Data_write,
    input  logic        mem_w,
    input  logic [2:0]  RAMCtrl,
    output logic [31:0] Data_read,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [AW-1:0] r_idx;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [2:0]  r_ctrl;
    logic [31:0] r_mem [DEPTH];

    logic          w_idle;
    logic          w_go_resp;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [31:0]   w_wdata;
    logic          w_we;
    logic [2:0]    w_ctrl;
    logic [3:0]    w_be;
    logic [31:0]   w_wword;
    logic [31:0]   w_rdata;
    logic          w_misalign;
    logic          w_fault;
    logic          w_unused_addr;

    assign w_unused_addr = ^Addr[31:AW+2];

    assign w_idle = (r_state == S_IDLE);
    // With zero latency the access completes on the accepting edge, so use live inputs.
    assign w_go_resp = (w_idle && req && (LATENCY == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));

    assign w_idx   = w_idle ? Addr[AW+1:2] : r_idx;
    assign w_off   = w_idle ? Addr[1:0]    : r_off;
    assign w_wdata = w_idle ? Data_write   : r_wdata;
    assign w_we    = w_idle ? mem_w        : r_we;
    assign w_ctrl  = w_idle ? RAMCtrl      : r_ctrl;

    ram_lane_align u_align (
        .i_ctrl     (w_ctrl),
        .i_off      (w_off),
        .i_wdata    (w_wdata),
        .i_rword    (r_mem[w_idx]),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign)
    );

`ifdef MISALIGN_TRAP_EN
    assign w_fault = rc_reserved(w_ctrl) || w_misalign;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign ^ (^w_be);
    assign w_fault = rc_reserved(w_ctrl);
`endif

    assign busy = !w_idle || req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_off     <= 2'b00;
            r_wdata   <= 32'h0;
            r_we      <= 1'b0;
            r_ctrl    <= RC_W;
            Data_read <= 32'h0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (w_go_resp) begin
                ready <= 1'b1;
                err   <= w_fault;
                if (!w_we && !w_fault) Data_read <= w_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_idx   <= Addr[AW+1:2];
                        r_off   <= Addr[1:0];
                        r_wdata <= Data_write;
                        r_we    <= mem_w;
                        r_ctrl  <= RAMCtrl;
                        r_cnt   <= LAT_M1;
                        r_state <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_go_resp && w_we && !w_fault) r_mem[w_idx] <= w_wword;
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: directed accesses push expected responses; a monitor
// pops and compares on every ready pulse.
module tb_ram_responder;
    import ram_pkg::*;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] Addr;
    logic [31:0] Data_write;
    logic        mem_w;
    logic [2:0]  RAMCtrl;
    logic [31:0] Data_read;
    logic        ready;
    logic        busy;
    logic        err;

    logic [32:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_responder #(.DEPTH(1024), .LATENCY(LAT), .AW(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .Addr       (Addr),
        .Data_write (Data_write),
        .mem_w      (mem_w),
        .RAMCtrl    (RAMCtrl),
        .Data_read  (Data_read),
        .ready      (ready),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (err) check("err_with_ready", {31'h0, ready}, 32'h1);
        if (ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("Data_read", Data_read, e[31:0]);
                check("err", {31'h0, err}, {31'h0, e[32]});
            end
        end
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] c, input logic [31:0] exp_rd, input logic exp_err);
        int lat = 0;
        int nb  = 0;
        bit seen = 0;
        @(posedge clk); #1;
        Addr = a; Data_write = d; mem_w = w; RAMCtrl = c; req = 1'b1;
        @(negedge clk);
        exp_q.push_back({exp_err, exp_rd});
        if (busy) nb++;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the access must use the latched values.
        req = 1'b0; Addr = ~a; Data_write = ~d; mem_w = ~w; RAMCtrl = ~c;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
            if (ready) seen = 1;
        end
        @(negedge clk);
        if (busy) nb++;
        check("ready_seen", {31'h0, seen}, 32'h1);
        check("ready_latency", lat, LAT + 1);
        check("busy_cycles", nb, LAT + 2);
    endtask

    initial begin
        logic [31:0] mis_rd;
        logic        mis_err;
        logic [31:0] rsv_rd;
        int c1 = 0;
        int c2 = 0;
        int nrdy = 0;
        bit seen = 0;

        rst = 1'b1; req = 1'b0; Addr = 32'h0; Data_write = 32'h0; mem_w = 1'b0; RAMCtrl = RC_W;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_Data_read", Data_read, 32'h0);
        check("reset_ready", {31'h0, ready}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);

        access(1'b1, 32'h10, 32'hDEADBEEF, RC_W, 32'h0, 1'b0);
        access(1'b0, 32'h10, 32'h0, RC_W, 32'hDEADBEEF, 1'b0);
        access(1'b1, 32'h10, 32'h11223344, RC_W, 32'hDEADBEEF, 1'b0);
        access(1'b1, 32'h11, 32'h000000AA, RC_B, 32'hDEADBEEF, 1'b0);
        access(1'b0, 32'h10, 32'h0, RC_W, 32'h1122AA44, 1'b0);
        access(1'b0, 32'h11, 32'h0, RC_B, 32'hFFFFFFAA, 1'b0);
        access(1'b0, 32'h11, 32'h0, RC_BU, 32'h000000AA, 1'b0);

        access(1'b1, 32'h20, 32'hCAFEF00D, RC_W, 32'h000000AA, 1'b0);
        access(1'b1, 32'h22, 32'h00008001, RC_H, 32'h000000AA, 1'b0);
        access(1'b0, 32'h22, 32'h0, RC_H, 32'hFFFF8001, 1'b0);
        access(1'b0, 32'h22, 32'h0, RC_HU, 32'h00008001, 1'b0);
        access(1'b0, 32'h20, 32'h0, RC_W, 32'h8001F00D, 1'b0);

`ifdef MISALIGN_TRAP_EN
        mis_rd = 32'h8001F00D; mis_err = 1'b1;
`else
        mis_rd = 32'h1122AA44; mis_err = 1'b0;
`endif
        access(1'b0, 32'h13, 32'h0, RC_W, mis_rd, mis_err);
        rsv_rd = mis_rd;

        access(1'b1, 32'h10, 32'h0, 3'b111, rsv_rd, 1'b1);
        access(1'b0, 32'h10, 32'h0, RC_W, 32'h1122AA44, 1'b0);

        access(1'b0, 32'h1010, 32'h0, RC_W, 32'h1122AA44, 1'b0);
        access(1'b1, 32'h1014, 32'h55667788, RC_W, 32'h1122AA44, 1'b0);
        access(1'b0, 32'h14, 32'h0, RC_W, 32'h55667788, 1'b0);

        // req held high: exactly one access per LAT+2 cycles, re-accepted on first idle cycle.
        @(posedge clk); #1;
        Addr = 32'h20; Data_write = 32'h0; mem_w = 1'b0; RAMCtrl = RC_W; req = 1'b1;
        @(negedge clk);
        exp_q.push_back({1'b0, 32'h8001F00D});
        exp_q.push_back({1'b0, 32'h8001F00D});
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); c1++;
            if (ready) seen = 1;
        end
        check("held_first_latency", c1, LAT + 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); c2++;
            if (ready) seen = 1;
        end
        check("held_gap", c2, LAT + 2);
        @(posedge clk); #1 req = 1'b0;
        repeat (6) @(negedge clk);

        // Store to 0x30 then abort a second store with reset during WAIT.
        access(1'b1, 32'h30, 32'hA5A5A5A5, RC_W, 32'h8001F00D, 1'b0);
        @(posedge clk); #1;
        Addr = 32'h30; Data_write = 32'h12345678; mem_w = 1'b1; RAMCtrl = RC_W; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_Data_read", Data_read, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready) nrdy++;
        end
        check("abort_no_ready", nrdy, 0);
        access(1'b0, 32'h30, 32'h0, RC_W, 32'hA5A5A5A5, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
